// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register: valid/ready handshake, optional skid entry,
// writeEN freeze, flush-to-bubble and saturating stall/drop statistics.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              writeEN,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic               accept;
    logic               emit;
    logic               stall_inc;
    logic [1:0]         held;
    logic [1:0]         drop_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // With a skid entry, in_ready decodes only the state register, so it has
    // no combinational path from out_ready.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !RST && writeEN && (state_q != ST_SKID);
        end else begin : g_noskid
            assign in_ready = !RST && writeEN && ((state_q == ST_EMPTY) || out_ready);
        end
    endgenerate

    assign out_valid = writeEN && (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = stall_q;
    assign drop_cnt  = drop_q;

    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready;

    always_comb begin
        held = 2'd0;
        case (state_q)
            ST_FULL: held = 2'd1;
            ST_SKID: held = 2'd2;
            default: held = 2'd0;
        endcase
    end

    // An entry emitted in the flush cycle left the stage and is not a drop.
    assign drop_inc = held - {1'b0, emit};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        drop_d  = drop_q;
        if (cnt_clr) begin
            stall_d = '0;
            drop_d  = '0;
        end else begin
            stall_d = sat_add(stall_q, {1'b0, stall_inc});
            if (flush) drop_d = sat_add(drop_q, drop_inc);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a skid instance (narrow counters) and a
// no-skid instance, each with a scoreboard queue fed on accept and drained on emit.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_we, a_flush, a_clr;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_stall, a_drop;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_we, b_flush, b_clr;
    logic [15:0] b_in_data, b_out_data;
    logic [7:0]  b_stall, b_drop;

    pipe_stage_buf #(.DATA_W(32), .SKID(1), .CNT_W(2)) u_a (
        .CLK(clk), .RST(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .writeEN(a_we), .flush(a_flush), .cnt_clr(a_clr),
        .stall_cnt(a_stall), .drop_cnt(a_drop)
    );

    pipe_stage_buf #(.DATA_W(16), .SKID(0), .CNT_W(8)) u_b (
        .CLK(clk), .RST(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .writeEN(b_we), .flush(b_flush), .cnt_clr(b_clr),
        .stall_cnt(b_stall), .drop_cnt(b_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] qa[$];
    logic [15:0] qb[$];

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                chk("A_emit_pending", 64'(qa.size() != 0), 64'h1);
                if (qa.size() != 0) chk("A_emit_data", 64'(a_out_data), 64'(qa.pop_front()));
            end
            if (a_flush) qa.delete();
            else if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                chk("B_emit_pending", 64'(qb.size() != 0), 64'h1);
                if (qb.size() != 0) chk("B_emit_data", 64'(b_out_data), 64'(qb.pop_front()));
            end
            if (b_flush) qb.delete();
            else if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        end
    end

    initial begin
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_we = 1; a_flush = 0; a_clr = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_we = 1; b_flush = 0; b_clr = 0;
        rst = 0;
        #1 rst = 1;
        tick(); tick();

        // reset state
        chk("rst_a_in_ready",  64'(a_in_ready),  64'h0);
        chk("rst_b_in_ready",  64'(b_in_ready),  64'h0);
        chk("rst_a_out_valid", 64'(a_out_valid), 64'h0);
        chk("rst_a_out_data",  64'(a_out_data),  64'h0);
        chk("rst_a_stall",     64'(a_stall),     64'h0);
        chk("rst_a_drop",      64'(a_drop),      64'h0);
        rst = 0;
        #1;
        chk("post_rst_a_in_ready", 64'(a_in_ready), 64'h1);
        chk("post_rst_b_in_ready", 64'(b_in_ready), 64'h1);

        // streaming, one word per cycle, 1-cycle latency
        a_out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1;
            a_in_data  = 32'(i);
            tick();
            chk("stream_valid", 64'(a_out_valid), 64'h1);
            chk("stream_data",  64'(a_out_data),  64'(i));
        end
        a_in_valid = 0;
        tick();
        chk("stream_drained", 64'(a_out_valid), 64'h0);
        chk("stream_no_stall", 64'(a_stall), 64'h0);

        // skid fill under backpressure, stall counting and saturation
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'hA1;
        tick();
        a_in_data = 32'hA2;
        tick();
        chk("skid_in_ready", 64'(a_in_ready), 64'h0);
        chk("skid_head",     64'(a_out_data), 64'hA1);
        chk("skid_stall1",   64'(a_stall),    64'h1);
        a_in_data = 32'hA3;
        tick();
        chk("skid_stall2",   64'(a_stall),    64'h2);
        chk("skid_in_ready2", 64'(a_in_ready), 64'h0);
        tick();
        chk("skid_stall3",   64'(a_stall),    64'h3);
        tick(); tick(); tick();
        chk("stall_sat",     64'(a_stall),    64'h3);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("stall_clr",     64'(a_stall),    64'h0);
        a_in_valid  = 0;
        a_out_ready = 1;
        tick();
        chk("release_valid", 64'(a_out_valid), 64'h1);
        chk("release_data",  64'(a_out_data),  64'hA2);
        chk("release_ready", 64'(a_in_ready),  64'h1);
        tick();
        chk("release_empty", 64'(a_out_valid), 64'h0);
        chk("release_stall", 64'(a_stall),     64'h0);

        // flush with two entries held, then with emit, then saturation
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'hB1; tick();
        a_in_data   = 32'hB2; tick();
        a_in_valid  = 0;
        a_flush     = 1; tick();
        a_flush     = 0;
        chk("flush2_valid", 64'(a_out_valid), 64'h0);
        chk("flush2_data",  64'(a_out_data),  64'h0);
        chk("flush2_drop",  64'(a_drop),      64'h2);
        a_in_valid  = 1;
        a_in_data   = 32'hF1; tick();
        a_in_data   = 32'hF2; tick();
        a_in_valid  = 0;
        a_out_ready = 1;
        a_flush     = 1; tick();
        a_flush     = 0;
        chk("flush_emit_drop",  64'(a_drop),      64'h3);
        chk("flush_emit_valid", 64'(a_out_valid), 64'h0);
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'hC1; tick();
        a_in_valid  = 0;
        a_flush     = 1; tick();
        a_flush     = 0;
        chk("drop_sat", 64'(a_drop), 64'h3);

        // writeEN freeze
        a_clr      = 1;
        a_in_valid = 1;
        a_in_data  = 32'hD1;
        tick();
        a_clr = 0;
        chk("we_pre_stall", 64'(a_stall), 64'h0);
        chk("we_pre_drop",  64'(a_drop),  64'h0);
        a_we        = 0;
        a_in_data   = 32'hD2;
        a_out_ready = 1;
        #1;
        chk("we_in_ready",  64'(a_in_ready),  64'h0);
        chk("we_out_valid", 64'(a_out_valid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("we_hold_data",  64'(a_out_data),  64'hD1);
            chk("we_hold_valid", 64'(a_out_valid), 64'h0);
            chk("we_hold_stall", 64'(a_stall),     64'h0);
        end
        a_we = 1;
        #1;
        chk("we_resume_valid", 64'(a_out_valid), 64'h1);
        chk("we_resume_ready", 64'(a_in_ready),  64'h1);
        tick();
        chk("we_next_data", 64'(a_out_data), 64'hD2);
        a_in_valid = 0;
        a_we       = 0;
        a_flush    = 1;
        tick();
        a_flush = 0;
        a_we    = 1;
        #1;
        chk("we_flush_valid", 64'(a_out_valid), 64'h0);
        chk("we_flush_data",  64'(a_out_data),  64'h0);

        // reset mid-stream
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'hE1;
        tick();
        tick();
        chk("mid_pre_stall", 64'(a_stall), 64'h1);
        #2 rst = 1;
        #1;
        chk("mid_rst_valid", 64'(a_out_valid), 64'h0);
        chk("mid_rst_data",  64'(a_out_data),  64'h0);
        chk("mid_rst_ready", 64'(a_in_ready),  64'h0);
        chk("mid_rst_stall", 64'(a_stall),     64'h0);
        chk("mid_rst_drop",  64'(a_drop),      64'h0);
        a_in_valid = 0;
        tick();
        rst = 0;
        #1;
        chk("mid_rst_release", 64'(a_in_ready), 64'h1);

        // no-skid instance: full backpressure, then emit+accept on one edge
        b_out_ready = 0;
        b_in_valid  = 1;
        b_in_data   = 16'h11;
        tick();
        chk("b_full_valid", 64'(b_out_valid), 64'h1);
        chk("b_full_data",  64'(b_out_data),  64'h11);
        chk("b_full_ready", 64'(b_in_ready),  64'h0);
        b_in_data = 16'h22;
        tick();
        chk("b_stall",      64'(b_stall),    64'h1);
        chk("b_hold_data",  64'(b_out_data), 64'h11);
        b_out_ready = 1;
        #1;
        chk("b_ready_comb", 64'(b_in_ready), 64'h1);
        tick();
        chk("b_swap_valid", 64'(b_out_valid), 64'h1);
        chk("b_swap_data",  64'(b_out_data),  64'h22);
        b_in_valid = 0;
        b_flush    = 1;
        tick();
        b_flush = 0;
        chk("b_flush_emit_drop", 64'(b_drop),      64'h0);
        chk("b_flush_valid",     64'(b_out_valid), 64'h0);
        b_out_ready = 0;
        b_in_valid  = 1;
        b_in_data   = 16'h33;
        tick();
        b_in_valid = 0;
        b_flush    = 1;
        tick();
        b_flush = 0;
        chk("b_flush_drop", 64'(b_drop), 64'h1);

        tick();
        chk("a_queue_drained", 64'(qa.size()), 64'h0);
        chk("b_queue_drained", 64'(qb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
